// File: rtl/wb_stage_if.sv
// Pipeline-side bundle for the write-back stage: MEM/WB inputs, ID read ports,
// EX forwarding tap and board-display outputs.
interface wb_stage_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic             WE;
    logic             Byte;
    logic             set;
    logic             sys;
    logic             lower;
    logic [1:0]       sel;
    logic [1:0]       data_in_re_choose;
    logic [4:0]       RW;
    logic [31:0]      PC;
    logic [31:0]      result;
    logic [31:0]      LO;
    logic [31:0]      data;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic             wb_we;
    logic [4:0]       wb_rw;
    logic [31:0]      wb_data;
    logic             halt;
    logic [31:0]      led_data;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output run, WE, Byte, set, sys, lower, sel, data_in_re_choose, RW, PC, result, LO,
               data, ra1, ra2,
        input  rd1, rd2, wb_we, wb_rw, wb_data, halt, led_data, retired_cnt
    );

    modport slave (
        input  run, WE, Byte, set, sys, lower, sel, data_in_re_choose, RW, PC, result, LO,
               data, ra1, ra2,
        output rd1, rd2, wb_we, wb_rw, wb_data, halt, led_data, retired_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: final write-data mux, 32x32 register file with write-through
// read ports, syscall display/halt and a saturating retired-instruction counter.
module wb_stage #(
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] SYS_PRINT = 32'd34
) (
    input logic       clk,
    input logic       clear,
    wb_stage_if.slave bus
);
    logic [31:0]      regs_q [32];
    logic             halt_q;
    logic [31:0]      led_q;
    logic [CNT_W-1:0] cnt_q;

    logic [7:0]  lane;
    logic [31:0] load_data;
    logic [31:0] wr_data;
    logic        we;
    logic        sys_fire;
    logic        retire;

    always_comb begin
        case (bus.sel)
            2'd0:    lane = bus.data[7:0];
            2'd1:    lane = bus.data[15:8];
            2'd2:    lane = bus.data[23:16];
            default: lane = bus.data[31:24];
        endcase
        if (!bus.Byte)      load_data = bus.data;
        else if (bus.lower) load_data = {24'b0, lane};
        else                load_data = {{24{lane[7]}}, lane};
    end

    always_comb begin
        case (bus.data_in_re_choose)
            2'b00:   wr_data = bus.set ? {31'b0, bus.result[0]} : bus.result;
            2'b01:   wr_data = load_data;
            2'b10:   wr_data = bus.PC + 32'd4;
            default: wr_data = bus.LO;
        endcase
    end

    assign we       = bus.run & bus.WE & ~halt_q & (bus.RW != 5'd0);
    assign sys_fire = bus.run & bus.sys & ~halt_q & (bus.PC != 32'd0);
    assign retire   = bus.run & ~halt_q & (bus.PC != 32'd0);

    // Same-cycle writes bypass to ID so no extra hazard stall is needed.
    always_comb begin
        if (bus.ra1 == 5'd0)                 bus.rd1 = 32'd0;
        else if (we && bus.ra1 == bus.RW)    bus.rd1 = wr_data;
        else                                 bus.rd1 = regs_q[bus.ra1];
        if (bus.ra2 == 5'd0)                 bus.rd2 = 32'd0;
        else if (we && bus.ra2 == bus.RW)    bus.rd2 = wr_data;
        else                                 bus.rd2 = regs_q[bus.ra2];
    end

    assign bus.wb_we       = we;
    assign bus.wb_rw       = bus.RW;
    assign bus.wb_data     = wr_data;
    assign bus.halt        = halt_q;
    assign bus.led_data    = led_q;
    assign bus.retired_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
            halt_q <= 1'b0;
            led_q  <= 32'd0;
            cnt_q  <= '0;
        end else begin
            if (we) regs_q[bus.RW] <= wr_data;
            // Syscall decodes $v0/$a0 straight from the register file, never the bypass.
            if (sys_fire) begin
                if (regs_q[2] == SYS_PRINT) led_q <= regs_q[4];
                else                        halt_q <= 1'b1;
            end
            if (retire && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage; counter width is narrowed so saturation is reachable.
module tb_wb_stage;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic clear;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    wb_stage_if #(.CNT_W(CW)) bus ();

    wb_stage #(.CNT_W(CW), .SYS_PRINT(32'd34)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.run = 1'b1; bus.WE = 1'b0; bus.Byte = 1'b0; bus.set = 1'b0; bus.sys = 1'b0;
        bus.lower = 1'b0; bus.sel = 2'd0; bus.data_in_re_choose = 2'b00; bus.RW = 5'd0;
        bus.PC = 32'd0; bus.result = 32'd0; bus.LO = 32'd0; bus.data = 32'd0;
        bus.ra1 = 5'd0; bus.ra2 = 5'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.WE = 1'b1; bus.RW = 5'd5; bus.result = 32'h1111; bus.PC = 32'h10;
        clear = 1'b0;
        step();
        bus.WE = 1'b0; bus.PC = 32'd0;
        do_clear();
        bus.ra1 = 5'd5;
        #1;
        n_vec++;
        if (bus.rd1 !== 32'd0) begin
            n_err++; $display("FAIL reset_rd1 got %h want %h", bus.rd1, 32'd0);
        end
        n_vec++;
        if (bus.halt !== 1'b0) begin
            n_err++; $display("FAIL reset_halt got %b want 0", bus.halt);
        end
        n_vec++;
        if (bus.retired_cnt !== '0) begin
            n_err++; $display("FAIL reset_cnt got %0d want 0", bus.retired_cnt);
        end
        n_vec++;
        if (bus.led_data !== 32'd0) begin
            n_err++; $display("FAIL reset_led got %h want 0", bus.led_data);
        end
    endtask

    task automatic test_byte_load();
        logic       byt [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0] sl  [6] = '{2'd3, 2'd3, 2'd1, 2'd0, 2'd0, 2'd2};
        logic       low [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] ev [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h80FF7F01,
                                32'h00000001, 32'hFFFFFFFF};
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            bus.data = 32'h80FF7F01; bus.data_in_re_choose = 2'b01; bus.RW = 5'd8;
            bus.WE = 1'b1; bus.PC = 32'h100; bus.Byte = byt[i]; bus.sel = sl[i];
            bus.lower = low[i];
            exp_q.push_back(ev[i]);
            step();
            bus.WE = 1'b0; bus.PC = 32'd0; bus.ra1 = 5'd8;
            #1;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (bus.rd1 !== exp_v) begin
                n_err++; $display("FAIL byte_load[%0d] r8 got %h want %h", i, bus.rd1, exp_v);
            end
        end
    endtask

    task automatic test_write_through();
        idle_inputs();
        bus.WE = 1'b1; bus.RW = 5'd9; bus.result = 32'h1234; bus.ra2 = 5'd9;
        bus.PC = 32'h104;
        #1;
        n_vec++;
        if (bus.rd2 !== 32'h1234) begin
            n_err++; $display("FAIL wt_bypass rd2 got %h want %h", bus.rd2, 32'h1234);
        end
        n_vec++;
        if (bus.wb_we !== 1'b1 || bus.wb_rw !== 5'd9) begin
            n_err++; $display("FAIL wt_tap we/rw got %b/%0d want 1/9", bus.wb_we, bus.wb_rw);
        end
        step();
        bus.WE = 1'b0; bus.result = 32'h0;
        #1;
        n_vec++;
        if (bus.rd2 !== 32'h1234) begin
            n_err++; $display("FAIL wt_stored rd2 got %h want %h", bus.rd2, 32'h1234);
        end
        bus.WE = 1'b1; bus.RW = 5'd0; bus.result = 32'd5; bus.ra2 = 5'd0;
        #1;
        n_vec++;
        if (bus.wb_we !== 1'b0 || bus.rd2 !== 32'd0) begin
            n_err++; $display("FAIL wt_r0 we/rd2 got %b/%h want 0/0", bus.wb_we, bus.rd2);
        end
        step();
        n_vec++;
        if (bus.rd2 !== 32'd0) begin
            n_err++; $display("FAIL wt_r0_after rd2 got %h want 0", bus.rd2);
        end
    endtask

    task automatic test_source_select();
        logic [1:0]  ch [3] = '{2'b10, 2'b11, 2'b00};
        logic [31:0] ev [3] = '{32'h00003004, 32'h0000DEAD, 32'h00000001};
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.data_in_re_choose = ch[i]; bus.PC = 32'h00003000; bus.LO = 32'hDEAD;
            bus.set = (i == 2); bus.result = 32'd3; bus.WE = 1'b1; bus.RW = 5'd10;
            exp_q.push_back(ev[i]);
            #1;
            n_vec++;
            if (bus.wb_data !== ev[i]) begin
                n_err++; $display("FAIL src[%0d] wb_data got %h want %h", i, bus.wb_data, ev[i]);
            end
            step();
            bus.WE = 1'b0; bus.ra1 = 5'd10;
            #1;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (bus.rd1 !== exp_v) begin
                n_err++; $display("FAIL src[%0d] r10 got %h want %h", i, bus.rd1, exp_v);
            end
        end
    endtask

    task automatic test_syscall();
        idle_inputs();
        do_clear();
        bus.WE = 1'b1; bus.PC = 32'h200; bus.RW = 5'd2; bus.result = 32'd34;
        step();
        bus.RW = 5'd4; bus.result = 32'hCAFE;
        step();
        bus.WE = 1'b0; bus.sys = 1'b1; bus.PC = 32'h208;
        step();
        bus.sys = 1'b0;
        n_vec++;
        if (bus.led_data !== 32'hCAFE || bus.halt !== 1'b0) begin
            n_err++; $display("FAIL sys_print led/halt got %h/%b want cafe/0", bus.led_data,
                              bus.halt);
        end
        bus.WE = 1'b1; bus.RW = 5'd2; bus.result = 32'd10; bus.PC = 32'h20C;
        step();
        bus.WE = 1'b0; bus.sys = 1'b1; bus.PC = 32'h210;
        #1;
        n_vec++;
        if (bus.halt !== 1'b0) begin
            n_err++; $display("FAIL sys_halt_early got %b want 0", bus.halt);
        end
        step();
        bus.sys = 1'b0;
        n_vec++;
        if (bus.halt !== 1'b1) begin
            n_err++; $display("FAIL sys_halt got %b want 1", bus.halt);
        end
        bus.WE = 1'b1; bus.RW = 5'd3; bus.result = 32'h77; bus.PC = 32'h214; bus.ra1 = 5'd3;
        #1;
        n_vec++;
        if (bus.wb_we !== 1'b0 || bus.rd1 !== 32'd0) begin
            n_err++; $display("FAIL halted_tap we/rd1 got %b/%h want 0/0", bus.wb_we, bus.rd1);
        end
        step();
        step();
        bus.WE = 1'b0;
        #1;
        n_vec++;
        if (bus.rd1 !== 32'd0) begin
            n_err++; $display("FAIL halted_r3 got %h want 0", bus.rd1);
        end
        n_vec++;
        if (bus.retired_cnt !== CW'(5) || bus.led_data !== 32'hCAFE) begin
            n_err++; $display("FAIL halted_frozen cnt/led got %0d/%h want 5/cafe",
                              bus.retired_cnt, bus.led_data);
        end
        do_clear();
        #1;
        n_vec++;
        if (bus.halt !== 1'b0) begin
            n_err++; $display("FAIL halt_clear got %b want 0", bus.halt);
        end
    endtask

    task automatic test_counter();
        logic [CW-1:0] cnt_m;
        idle_inputs();
        do_clear();
        cnt_m = '0;
        for (int i = 0; i < 5; i++) begin
            bus.PC = (i == 1 || i == 3) ? 32'd0 : 32'h400 + 32'(i) * 32'd4;
            if (bus.PC != 32'd0) cnt_m = cnt_m + 1'b1;
            exp_q.push_back(32'(cnt_m));
            step();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (32'(bus.retired_cnt) !== exp_v) begin
                n_err++; $display("FAIL cnt_mix[%0d] got %0d want %0d", i, bus.retired_cnt, exp_v);
            end
        end
        bus.run = 1'b0; bus.PC = 32'h500; bus.WE = 1'b1; bus.RW = 5'd11; bus.result = 32'h55;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (bus.retired_cnt !== CW'(3) || bus.wb_we !== 1'b0) begin
                n_err++; $display("FAIL run0[%0d] cnt/we got %0d/%b want 3/0", i,
                                  bus.retired_cnt, bus.wb_we);
            end
        end
        bus.run = 1'b1; bus.WE = 1'b0; bus.ra1 = 5'd11;
        #1;
        n_vec++;
        if (bus.rd1 !== 32'd0) begin
            n_err++; $display("FAIL run0_nowrite r11 got %h want 0", bus.rd1);
        end
        cnt_m = CW'(3);
        for (int i = 0; i < 16; i++) begin
            if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
            exp_q.push_back(32'(cnt_m));
            step();
            exp_v = exp_q.pop_front();
            n_vec++;
            if (32'(bus.retired_cnt) !== exp_v) begin
                n_err++; $display("FAIL cnt_sat[%0d] got %0d want %0d", i, bus.retired_cnt, exp_v);
            end
        end
    endtask

    initial begin
        clear = 1'b1;
        idle_inputs();
        test_reset();
        test_byte_load();
        test_write_through();
        test_source_select();
        test_syscall();
        test_counter();
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
